// File: rtl/module_exec_ctrl.sv
// ============================================================================
// module_exec_ctrl : four-state instruction controller driving an external
//                    sign-magnitude ALU from an 8 x 16-bit register file.
// Revision 1.0
// ============================================================================
`default_nettype none

module module_exec_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic [15:0] instr,
  output logic [15:0] alu_a,
  output logic [15:0] alu_b,
  output logic [2:0]  alu_op,
  input  logic [15:0] alu_result,
  output logic [15:0] disp_value,
  output logic        disp_valid,
  output logic        done,
  output logic        busy
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_READ  = 2'd1;
  localparam logic [1:0] S_EXEC  = 2'd2;
  localparam logic [1:0] S_WRITE = 2'd3;

  localparam logic [2:0] OP_LOAD    = 3'd0;
  localparam logic [2:0] OP_ADD     = 3'd1;
  localparam logic [2:0] OP_ADDI    = 3'd2;
  localparam logic [2:0] OP_SUB     = 3'd3;
  localparam logic [2:0] OP_SUBI    = 3'd4;
  localparam logic [2:0] OP_MUL     = 3'd5;
  localparam logic [2:0] OP_CLEAR   = 3'd6;
  localparam logic [2:0] OP_DISPLAY = 3'd7;

  logic [1:0]  r_state;
  logic [15:0] r_instr;
  logic [15:0] r_rf [8];
  logic [15:0] r_alu_a;
  logic [15:0] r_alu_b;
  logic [2:0]  r_alu_op;
  logic [15:0] r_result;
  logic [15:0] r_disp_value;

  logic [2:0]  w_op;
  logic [2:0]  w_rd;
  logic [2:0]  w_rs1;
  logic [2:0]  w_rs2;
  logic [6:0]  w_imm;
  logic [15:0] w_imm16;
  logic        w_uses_alu;

  assign w_op  = r_instr[15:13];
  assign w_rd  = r_instr[12:10];
  assign w_rs1 = r_instr[9:7];
  assign w_imm = r_instr[6:0];
  assign w_rs2 = w_imm[2:0];

  // A negative-zero immediate collapses to plain zero.
  assign w_imm16    = (w_imm[5:0] == 6'd0) ? 16'h0000 : {w_imm[6], 9'b0, w_imm[5:0]};
  assign w_uses_alu = (w_op >= OP_ADD) && (w_op <= OP_MUL);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_instr      <= 16'h0000;
      r_alu_a      <= 16'h0000;
      r_alu_b      <= 16'h0000;
      r_alu_op     <= 3'd0;
      r_result     <= 16'h0000;
      r_disp_value <= 16'h0000;
      for (int i = 0; i < 8; i++) r_rf[i] <= 16'h0000;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (instr_valid) begin
            r_instr <= instr;
            r_state <= S_READ;
          end
        end
        S_READ: begin
          r_alu_op <= w_op;
          r_alu_a  <= r_rf[w_rs1];
          case (w_op)
            OP_ADD, OP_SUB, OP_MUL: r_alu_b <= r_rf[w_rs2];
            OP_ADDI, OP_SUBI:       r_alu_b <= w_imm16;
            default:                r_alu_b <= 16'h0000;
          endcase
          r_state <= S_EXEC;
        end
        S_EXEC: begin
          if (w_uses_alu) r_result <= alu_result;
          // Display value lands together with the pulse asserted in WRITE.
          if (w_op == OP_DISPLAY) r_disp_value <= r_rf[w_rd];
          r_state <= S_WRITE;
        end
        default: begin
          case (w_op)
            OP_LOAD:    r_rf[w_rd] <= w_imm16;
            OP_CLEAR:   for (int i = 0; i < 8; i++) r_rf[i] <= 16'h0000;
            OP_DISPLAY: ;
            default:    r_rf[w_rd] <= r_result;
          endcase
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign instr_ready = (r_state == S_IDLE);
  assign busy        = (r_state != S_IDLE);
  assign done        = (r_state == S_WRITE);
  assign disp_valid  = (r_state == S_WRITE) && (w_op == OP_DISPLAY);
  assign alu_a       = r_alu_a;
  assign alu_b       = r_alu_b;
  assign alu_op      = r_alu_op;
  assign disp_value  = r_disp_value;

endmodule

`default_nettype wire

// File: doc/module_exec_ctrl.md
MODULE_EXEC_CTRL -- requirements
Module: module_exec_ctrl

Interface
REQ-001 Parameters: none; word width 16, register count 8 and instruction format are fixed.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 instr_valid  input  1  upstream asserts when instr holds an instruction.
REQ-005 instr_ready  output  1  high when block can accept an instruction.
REQ-006 instr  input  16  opcode[15:13], rd[12:10], rs1[9:7], imm[6:0]; rs2 = imm[2:0].
REQ-007 alu_a  output  16  ALU operand A, sign-magnitude, registered.
REQ-008 alu_b  output  16  ALU operand B, sign-magnitude, registered.
REQ-009 alu_op  output  3  ALU opcode, registered.
REQ-010 alu_result  input  16  combinational sign-magnitude result from ALU.
REQ-011 disp_value  output  16  value shown by last DISPLAY, held until next DISPLAY or reset.
REQ-012 disp_valid  output  1  one-cycle pulse when disp_value updates.
REQ-013 done  output  1  one-cycle pulse when an instruction retires.
REQ-014 busy  output  1  high in any state other than IDLE.

Function
REQ-015 Opcodes: LOAD=0, ADD=1, ADDI=2, SUB=3, SUBI=4, MUL=5, CLEAR=6, DISPLAY=7.
REQ-016 Register file: 8 x 16-bit sign-magnitude registers R0-R7, all writable, no hardwired zero.
REQ-017 FSM states IDLE, READ, EXEC, WRITE; sequence IDLE->READ->EXEC->WRITE->IDLE, no other transitions.
REQ-018 instr_ready = 1 only in IDLE; accept when instr_valid && instr_ready; instruction latched that cycle; IDLE->READ.
REQ-019 instr_valid outside IDLE is ignored; no queuing.
REQ-020 Immediate extension: imm16 = {imm[6], 9'b0, imm[5:0]}; imm = 7'b1000000 (-0) extends to 16'h0000.
REQ-021 READ: alu_op <= opcode; alu_a <= R[rs1]; alu_b <= R[rs2] for ADD/SUB/MUL, imm16 for ADDI/SUBI, 16'h0000 otherwise.
REQ-022 EXEC: capture alu_result into internal result register for opcodes 1-5.
REQ-023 WRITE, opcodes 1-5: R[rd] <= captured result.
REQ-024 WRITE, LOAD: R[rd] <= imm16; ALU result ignored.
REQ-025 WRITE, CLEAR: all eight registers <= 16'h0000.
REQ-026 WRITE, DISPLAY: disp_value <= R[rd]; disp_valid = 1 for that cycle; no register written.
REQ-027 done = 1 in WRITE for every opcode; latency from accept edge to done = 3 cycles; throughput 1 instruction per 4 cycles.
REQ-028 Operand hazards: READ sees all writes of previous instructions; rd = rs1 = rs2 is legal.
REQ-029 Arithmetic overflow: no detection; ALU result is written back unmodified.
REQ-030 alu_a/alu_b/alu_op hold their values outside READ.

Reset
REQ-031 rst_n low: state=IDLE; R0-R7, alu_a, alu_b, disp_value = 16'h0000; alu_op = 3'd0; disp_valid, done, busy = 0; instr_ready = 1 after reset release.
REQ-032 Reset in READ, EXEC or WRITE aborts the instruction: no register write and no done or disp_valid pulse after reset assertion.
REQ-033 First accept allowed on the first rising edge with rst_n high.

Verification
REQ-034 LOAD R1,#5 (instr 16'h0405) -> done 3 cycles after accept; R1 = 16'h0005; busy high for 3 cycles.
REQ-035 LOAD R2,#-3 (imm 7'h43), then ADD R3,R1,R2 with real ALU -> alu_a=16'h0005, alu_b=16'h8003, alu_op=1; R3 = 16'h0002.
REQ-036 SUBI R4,R1,#10 -> alu_b = 16'h000A; R4 = 16'h8005; then DISPLAY R4 -> disp_value = 16'h8005 with a single disp_valid pulse.
REQ-037 instr_valid held high continuously with 4 instructions -> one accept every 4 cycles; instructions in busy cycles are not accepted.
REQ-038 CLEAR after R1-R4 loaded -> all registers read 16'h0000; LOAD R5,#-0 -> R5 = 16'h0000.
REQ-039 rst_n pulsed low during EXEC of ADD R6,R1,R1 -> R6 stays 16'h0000; no done pulse; instr_ready = 1 after reset release.
